// File: rtl/dcache_refill_unit_pkg.sv
// Shared widths, access-size encoding and FSM state codes for the D-cache refill unit.
package dcache_pkg;
  localparam int IDX_W      = 5;
  localparam int OFF_W      = 5;
  localparam int TAG_W      = 19;
  localparam int WAYS       = 2;
  localparam int LINE_BYTES = 128;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_INVAL = 3'd1;
  localparam state_t S_REQ   = 3'd2;
  localparam state_t S_BEAT  = 3'd3;
  localparam state_t S_TAGW  = 3'd4;
  localparam state_t S_DONE  = 3'd5;
endpackage

// File: rtl/dcache_refill_unit_if.sv
// Load-queue request port, memory bus, data/tag SRAM write ports and FSM debug of the refill unit.
interface dcache_refill_unit_if #(
  parameter int IDX_W = dcache_pkg::IDX_W,
  parameter int OFF_W = dcache_pkg::OFF_W,
  parameter int TAG_W = dcache_pkg::TAG_W
);
  import dcache_pkg::*;
  localparam int BRAM_AW = $clog2(dcache_pkg::WAYS) + IDX_W + OFF_W;

  // Handshakes: bus requests transfer on a cycle with bus_req_vld_o && bus_req_rdy_i, and
  // vld/addr/len/size stay stable until then; every bus_rsp_vld_i beat is consumed; dc_req is
  // a level held by the requester until the one-cycle dc_cmp pulse.
  logic                 dc_req;
  logic [31:0]          dc_addr;
  logic [1:0]           dc_op;
  logic                 dc_uncached;
  logic [31:0]          dc_data;
  logic                 dc_cmp;
  logic                 dc_err_o;
  logic                 bus_req_vld_o;
  logic                 bus_req_rdy_i;
  logic [31:0]          bus_req_addr_o;
  logic [OFF_W-1:0]     bus_req_len_o;
  logic [1:0]           bus_req_size_o;
  logic                 bus_rsp_vld_i;
  logic [31:0]          bus_rsp_data_i;
  logic                 bus_rsp_err_i;
  logic                 bram_wr_en_o;
  logic [BRAM_AW-1:0]   bram_wr_addr_o;
  logic [31:0]          bram_wr_data_o;
  logic                 tag_wr_en_o;
  logic                 tag_wr_way_o;
  logic [IDX_W-1:0]     tag_wr_idx_o;
  logic [TAG_W-1:0]     tag_wr_tag_o;
  logic                 tag_wr_vld_o;
  state_t               dbg_state_o;

  modport master (
    input  dc_req, dc_addr, dc_op, dc_uncached,
    output dc_data, dc_cmp, dc_err_o,
    output bus_req_vld_o, bus_req_addr_o, bus_req_len_o, bus_req_size_o,
    input  bus_req_rdy_i, bus_rsp_vld_i, bus_rsp_data_i, bus_rsp_err_i,
    output bram_wr_en_o, bram_wr_addr_o, bram_wr_data_o,
    output tag_wr_en_o, tag_wr_way_o, tag_wr_idx_o, tag_wr_tag_o, tag_wr_vld_o,
    output dbg_state_o
  );

  modport slave (
    output dc_req, dc_addr, dc_op, dc_uncached,
    input  dc_data, dc_cmp, dc_err_o,
    input  bus_req_vld_o, bus_req_addr_o, bus_req_len_o, bus_req_size_o,
    output bus_req_rdy_i, bus_rsp_vld_i, bus_rsp_data_i, bus_rsp_err_i,
    input  bram_wr_en_o, bram_wr_addr_o, bram_wr_data_o,
    input  tag_wr_en_o, tag_wr_way_o, tag_wr_idx_o, tag_wr_tag_o, tag_wr_vld_o,
    input  dbg_state_o
  );
endinterface

// File: rtl/dcache_refill_unit_rr_repl.sv
// One round-robin victim bit per cache index; the bit flips when a refill of that index succeeds.
module dcache_rr_repl #(
  parameter int IDX_W = dcache_pkg::IDX_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_way_o,
  input  logic             flip_en_i,
  input  logic [IDX_W-1:0] flip_idx_i
);
  logic [2**IDX_W-1:0] rr_q, rr_d;

  always_comb begin
    rr_d = rr_q;
    if (flip_en_i) rr_d[flip_idx_i] = ~rr_q[flip_idx_i];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_q <= '0;
    else         rr_q <= rr_d;
  end

  assign rd_way_o = rr_q[rd_idx_i];
endmodule

// File: rtl/dcache_refill_unit.sv
// Serves load-queue misses: 32-beat line refill into the 2-way data SRAM plus tag update,
// or a single-beat uncached read returned on dc_data.
module dcache_refill_unit #(
  parameter int IDX_W = dcache_pkg::IDX_W,
  parameter int OFF_W = dcache_pkg::OFF_W,
  parameter int TAG_W = dcache_pkg::TAG_W
) (
  input logic                  core_clock_i,
  input logic                  core_reset_ni,
  dcache_refill_unit_if.master bus_if
);
  import dcache_pkg::*;

  localparam int LINE_LSB = OFF_W + 2;

  state_t           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [1:0]       op_q, op_d;
  logic             unc_q, unc_d;
  logic             way_q, way_d;
  logic [OFF_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [31:0]      data_q, data_d;

  logic             rr_way;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             in_req, in_inval, in_tagw, bram_en, tag_en;

  assign idx      = addr_q[LINE_LSB +: IDX_W];
  assign tag      = addr_q[LINE_LSB + IDX_W +: TAG_W];
  assign in_req   = (state_q == S_REQ);
  assign in_inval = (state_q == S_INVAL);
  assign in_tagw  = (state_q == S_TAGW);

  dcache_rr_repl #(.IDX_W(IDX_W)) u_rr (
    .clk_i      (core_clock_i),
    .rst_ni     (core_reset_ni),
    .rd_idx_i   (idx),
    .rd_way_o   (rr_way),
    .flip_en_i  (in_tagw && !err_q),
    .flip_idx_i (idx)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    op_d    = op_q;
    unc_d   = unc_q;
    way_d   = way_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (bus_if.dc_req) begin
          addr_d  = bus_if.dc_addr;
          op_d    = bus_if.dc_op;
          unc_d   = bus_if.dc_uncached;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = bus_if.dc_uncached ? S_REQ : S_INVAL;
        end
      end
      S_INVAL: begin
        way_d   = rr_way;
        state_d = S_REQ;
      end
      S_REQ: begin
        if (bus_if.bus_req_rdy_i) state_d = S_BEAT;
      end
      S_BEAT: begin
        if (bus_if.bus_rsp_vld_i) begin
          if (unc_q) begin
            data_d  = bus_if.bus_rsp_data_i;
            err_d   = bus_if.bus_rsp_err_i;
            state_d = S_DONE;
          end else begin
            // Counter wraps to zero on the last beat, leaving it clean for the next refill.
            err_d = err_q | bus_if.bus_rsp_err_i;
            cnt_d = cnt_q + OFF_W'(1);
            if (&cnt_q) state_d = S_TAGW;
          end
        end
      end
      S_TAGW:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge core_clock_i or negedge core_reset_ni) begin
    if (!core_reset_ni) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      op_q    <= '0;
      unc_q   <= 1'b0;
      way_q   <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      unc_q   <= unc_d;
      way_q   <= way_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  // Write-port fields are forced to zero when idle so the SRAMs never see stray addresses.
  assign bram_en = (state_q == S_BEAT) && !unc_q && bus_if.bus_rsp_vld_i;
  assign tag_en  = in_inval || in_tagw;

  assign bus_if.bus_req_vld_o  = in_req;
  assign bus_if.bus_req_addr_o = !in_req ? 32'd0 :
                                 unc_q   ? addr_q : {addr_q[31:LINE_LSB], {LINE_LSB{1'b0}}};
  assign bus_if.bus_req_len_o  = (in_req && !unc_q) ? '1 : '0;
  assign bus_if.bus_req_size_o = !in_req ? 2'd0 : unc_q ? op_q : 2'(SZ_W);

  assign bus_if.bram_wr_en_o   = bram_en;
  assign bus_if.bram_wr_addr_o = bram_en ? {way_q, idx, cnt_q} : '0;
  assign bus_if.bram_wr_data_o = bram_en ? bus_if.bus_rsp_data_i : 32'd0;

  assign bus_if.tag_wr_en_o    = tag_en;
  assign bus_if.tag_wr_way_o   = in_inval ? rr_way : (in_tagw ? way_q : 1'b0);
  assign bus_if.tag_wr_idx_o   = tag_en ? idx : '0;
  assign bus_if.tag_wr_tag_o   = tag_en ? tag : '0;
  assign bus_if.tag_wr_vld_o   = in_tagw && !err_q;

  assign bus_if.dc_cmp         = (state_q == S_DONE);
  assign bus_if.dc_err_o       = (state_q == S_DONE) && err_q;
  assign bus_if.dc_data        = data_q;
  assign bus_if.dbg_state_o    = state_q;
endmodule

// File: tb/tb_dcache_refill_unit.sv
// Directed bench for dcache_refill_unit: transaction table, bus responder model, write scoreboards.
module tb_dcache_refill_unit;
  import dcache_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  dcache_refill_unit_if ifc ();

  dcache_refill_unit dut (
    .core_clock_i  (clk),
    .core_reset_ni (rst_n),
    .bus_if        (ifc.master)
  );

  // ---------------- bookkeeping ----------------
  int n_chk  = 0;
  int n_fail = 0;
  int cmp_cnt = 0;
  int n_exp_cmp = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [159:0] all_outs();
    return {ifc.dc_data, ifc.dc_cmp, ifc.dc_err_o, ifc.bus_req_vld_o, ifc.bus_req_addr_o,
            ifc.bus_req_len_o, ifc.bus_req_size_o, ifc.bram_wr_en_o, ifc.bram_wr_addr_o,
            ifc.bram_wr_data_o, ifc.tag_wr_en_o, ifc.tag_wr_way_o, ifc.tag_wr_idx_o,
            ifc.tag_wr_tag_o, ifc.tag_wr_vld_o};
  endfunction

  // Scoreboards: bram {way,idx,word,data}; tag {chk_tag,way,idx,tag,vld}
  logic [42:0] exp_bram_q[$];
  logic [26:0] exp_tag_q[$];
  logic [42:0] e_b;
  logic [26:0] e_t;

  logic [31:0] exp_bus_addr;
  logic [4:0]  exp_len;
  logic [1:0]  exp_size;

  // ---------------- bus responder + monitor ----------------
  int          rdy_wait_cfg = 0;
  int          gap_cfg      = 0;
  int          err_beat_cfg = -1;
  logic [31:0] data_base_cfg = 32'd0;
  int          rdy_cnt = 0, rsp_left = 0, gap_cnt = 0, beat_idx = 0;
  logic        hs_pend = 1'b0;
  logic [4:0]  pend_len = 5'd0;

  always @(negedge clk) begin
    ifc.bus_rsp_vld_i  = 1'b0;
    ifc.bus_rsp_err_i  = 1'b0;
    ifc.bus_rsp_data_i = 32'd0;
    ifc.bus_req_rdy_i  = 1'b0;
    if (!rst_n) begin
      rdy_cnt  = 0;
      rsp_left = 0;
      hs_pend  = 1'b0;
    end else begin
      if (hs_pend) begin
        rsp_left = int'(pend_len) + 1;
        gap_cnt  = gap_cfg;
        beat_idx = 0;
        hs_pend  = 1'b0;
      end
      if (rsp_left > 0) begin
        if (gap_cnt < gap_cfg) gap_cnt++;
        else begin
          ifc.bus_rsp_vld_i  = 1'b1;
          ifc.bus_rsp_data_i = data_base_cfg + 32'(beat_idx);
          ifc.bus_rsp_err_i  = (beat_idx == err_beat_cfg);
          beat_idx++;
          rsp_left--;
          gap_cnt = 0;
        end
      end
      if (ifc.bus_req_vld_o) begin
        if (rdy_cnt >= rdy_wait_cfg) begin
          ifc.bus_req_rdy_i = 1'b1;
          hs_pend  = 1'b1;
          pend_len = ifc.bus_req_len_o;
          rdy_cnt  = 0;
        end else rdy_cnt++;
      end
    end
    #1;
    if (rst_n) begin
      if (ifc.bus_req_vld_o) begin
        check("bus_addr", ifc.bus_req_addr_o, exp_bus_addr);
        check("bus_len",  ifc.bus_req_len_o,  exp_len);
        check("bus_size", ifc.bus_req_size_o, exp_size);
      end
      if (ifc.bram_wr_en_o || ifc.tag_wr_en_o)
        check("bram_tag_excl", ifc.bram_wr_en_o & ifc.tag_wr_en_o, 0);
      if (ifc.bram_wr_en_o) begin
        if (exp_bram_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL bram_unexpected: addr 0x%0h data 0x%0h, expected no write",
                   ifc.bram_wr_addr_o, ifc.bram_wr_data_o);
        end else begin
          e_b = exp_bram_q.pop_front();
          check("bram_wr", {ifc.bram_wr_addr_o, ifc.bram_wr_data_o}, e_b);
        end
      end
      if (ifc.tag_wr_en_o) begin
        if (exp_tag_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL tag_unexpected: way %0d idx 0x%0h, expected no write",
                   ifc.tag_wr_way_o, ifc.tag_wr_idx_o);
        end else begin
          e_t = exp_tag_q.pop_front();
          check("tag_wr", {ifc.tag_wr_way_o, ifc.tag_wr_idx_o,
                           e_t[26] ? ifc.tag_wr_tag_o : 19'd0, ifc.tag_wr_vld_o}, e_t[25:0]);
        end
      end
      if (ifc.dc_cmp) cmp_cnt++;
    end
  end

  // ---------------- transaction table ----------------
  typedef struct {
    logic [31:0] addr;
    logic [1:0]  op;
    logic        unc;
    int          rdy_wait;
    int          gap;
    int          err_beat;
    logic [31:0] base;
    int          exp_lat;
    logic        exp_err;
    logic [31:0] exp_data;
    logic        exp_way;
  } vec_t;

  vec_t vecs[6];

  task automatic push_cached(input vec_t v, input int n_beats, input logic with_tagw);
    logic [4:0]  idx;
    logic [18:0] tag;
    idx = v.addr[11:7];
    tag = v.addr[30:12];
    exp_tag_q.push_back({1'b0, v.exp_way, idx, 19'd0, 1'b0});
    for (int k = 0; k < n_beats; k++)
      exp_bram_q.push_back({v.exp_way, idx, 5'(k), v.base + 32'(k)});
    if (with_tagw) exp_tag_q.push_back({1'b1, v.exp_way, idx, tag, ~v.exp_err});
  endtask

  task automatic setup_bus(input vec_t v);
    rdy_wait_cfg  = v.rdy_wait;
    gap_cfg       = v.gap;
    err_beat_cfg  = v.err_beat;
    data_base_cfg = v.base;
    if (v.unc) begin
      exp_bus_addr = v.addr; exp_len = 5'd0; exp_size = v.op;
    end else begin
      exp_bus_addr = {v.addr[31:7], 7'd0}; exp_len = 5'd31; exp_size = 2'd2;
    end
  endtask

  task automatic run_txn(input vec_t v, input int id);
    logic got;
    int   start, lat;
    setup_bus(v);
    if (!v.unc) push_cached(v, 32, 1'b1);
    @(negedge clk);
    ifc.dc_req = 1'b1; ifc.dc_addr = v.addr; ifc.dc_op = v.op; ifc.dc_uncached = v.unc;
    start = cyc;
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk); #2;
      if (i == 0) check($sformatf("first_state[%0d]", id), ifc.dbg_state_o, v.unc ? S_REQ : S_INVAL);
      if (ifc.dc_cmp) begin
        got = 1'b1;
        lat = cyc - start;
        check($sformatf("latency[%0d]", id), lat, v.exp_lat);
        check($sformatf("dc_err[%0d]", id),  ifc.dc_err_o, v.exp_err);
        check($sformatf("dc_data[%0d]", id), ifc.dc_data, v.exp_data);
      end
    end
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL cmp_timeout[%0d]: no dc_cmp within 400 cycles", id);
    end
    n_exp_cmp++;
    @(negedge clk);
    ifc.dc_req = 1'b0;
    #2;
    check($sformatf("cmp_count[%0d]", id), cmp_cnt, n_exp_cmp);
    check($sformatf("bram_left[%0d]", id), exp_bram_q.size(), 0);
    check($sformatf("tag_left[%0d]", id),  exp_tag_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  vec_t vr;
  logic seen;

  initial begin
    ifc.dc_req = 1'b0; ifc.dc_addr = 32'd0; ifc.dc_op = 2'd0; ifc.dc_uncached = 1'b0;

    //          addr          op    unc   rdyw gap errb base           lat  err   data           way
    vecs[0] = '{32'h0000_1A84, 2'd2, 1'b0, 0,   0,  -1,  32'h1000_0000, 36,  1'b0, 32'h0,         1'b0};
    vecs[1] = '{32'h8000_0004, 2'd1, 1'b1, 0,   0,  -1,  32'hDEAD_BEEF, 3,   1'b0, 32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{32'h0000_2100, 2'd2, 1'b0, 5,   4,  -1,  32'h2000_0000, 165, 1'b0, 32'hDEAD_BEEF, 1'b0};
    vecs[3] = '{32'h0000_3A84, 2'd0, 1'b0, 0,   0,  7,   32'h3000_0000, 36,  1'b1, 32'hDEAD_BEEF, 1'b1};
    vecs[4] = '{32'h0000_0180, 2'd2, 1'b0, 0,   0,  -1,  32'h4000_0000, 36,  1'b0, 32'hDEAD_BEEF, 1'b0};
    vecs[5] = '{32'h0000_5180, 2'd2, 1'b0, 0,   0,  -1,  32'h5000_0000, 36,  1'b0, 32'hDEAD_BEEF, 1'b1};

    repeat (3) @(negedge clk);
    #2;
    check("reset_outs", all_outs(), 0);
    check("reset_state", ifc.dbg_state_o, S_IDLE);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_txn(vecs[i], i);

    // Reset during beat 10 of a refill to idx 0x15 (victim way1 after the errored refill).
    vr = '{32'h0000_7A84, 2'd2, 1'b0, 0, 0, -1, 32'h6000_0000, 36, 1'b0, 32'h0, 1'b1};
    setup_bus(vr);
    push_cached(vr, 11, 1'b0);
    @(negedge clk);
    ifc.dc_req = 1'b1; ifc.dc_addr = vr.addr; ifc.dc_op = vr.op; ifc.dc_uncached = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk); #2;
      if (exp_bram_q.size() == 0 && exp_tag_q.size() == 0) seen = 1'b1;
    end
    check("beat10_reached", seen, 1'b1);
    rst_n = 1'b0;
    ifc.dc_req = 1'b0;
    #1;
    check("midreset_outs", all_outs(), 0);
    check("midreset_state", ifc.dbg_state_o, S_IDLE);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Fresh refill to the same index: round-robin bit back to 0, dc_data cleared by reset.
    vr = '{32'h0000_7A84, 2'd2, 1'b0, 0, 0, -1, 32'h7000_0000, 36, 1'b0, 32'h0, 1'b0};
    run_txn(vr, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
